// File: rtl/adxl345_spi_responder_pkg.sv
// Shared types and constants for the ADXL345 SPI responder.
// Holds the FSM state enum, the register address map, register reset values
// and the packed x/y/z sample payload.
package adxl_resp_pkg;

  localparam int unsigned AXIS_W   = 16;
  localparam int unsigned ADDR_W   = 6;
  localparam int unsigned PHASE_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_RD,
    ST_WR
  } state_e;

  // Last field is the least significant: byte 0 of the flat vector is DATAX0.
  typedef struct packed {
    logic [AXIS_W-1:0] z;
    logic [AXIS_W-1:0] y;
    logic [AXIS_W-1:0] x;
  } sample_t;

  localparam logic [ADDR_W-1:0] ADDR_DEVID       = 6'h00;
  localparam logic [ADDR_W-1:0] ADDR_BW_RATE     = 6'h2C;
  localparam logic [ADDR_W-1:0] ADDR_POWER_CTL   = 6'h2D;
  localparam logic [ADDR_W-1:0] ADDR_INT_SOURCE  = 6'h30;
  localparam logic [ADDR_W-1:0] ADDR_DATA_FORMAT = 6'h31;
  localparam logic [ADDR_W-1:0] ADDR_DATAX0      = 6'h32;
  localparam logic [ADDR_W-1:0] ADDR_DATAZ1      = 6'h37;

  localparam logic [7:0] BW_RATE_RST     = 8'h0A;
  localparam logic [7:0] POWER_CTL_RST   = 8'h00;
  localparam logic [7:0] DATA_FORMAT_RST = 8'h00;

  function automatic logic is_data_addr(input logic [ADDR_W-1:0] a);
    return (a >= ADDR_DATAX0) && (a <= ADDR_DATAZ1);
  endfunction

  function automatic logic is_writable(input logic [ADDR_W-1:0] a);
    return (a == ADDR_BW_RATE) || (a == ADDR_POWER_CTL) || (a == ADDR_DATA_FORMAT);
  endfunction

endpackage

// File: rtl/adxl345_spi_responder_if.sv
// SPI bus between the accelerometer controller (master) and the responder (slave).
//   spi_sclk : SPI clock, idles high (mode 3)
//   spi_cs   : chip select, active low
//   spi_mosi : master to slave data
//   spi_miso : slave to master data
interface adxl345_spi_responder_if;
  logic spi_sclk;
  logic spi_cs;
  logic spi_mosi;
  logic spi_miso;

  modport master (output spi_sclk, output spi_cs, output spi_mosi, input spi_miso);
  modport slave  (input spi_sclk, input spi_cs, input spi_mosi, output spi_miso);
endinterface

// File: rtl/adxl345_spi_responder_sync_edge.sv
// spi_sync_edge: 2-flop synchroniser with one-cycle rise/fall pulses.
//   clk, rst_n : system clock, async active-low reset
//   d          : asynchronous input
//   q          : synchronised level (registered)
//   rise_c     : combinational pulse, q went 0 -> 1
//   fall_c     : combinational pulse, q went 1 -> 0
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise_c,
  output logic fall_c
);

  logic meta;
  logic q_d;

  // Reset to the idle level so no spurious edge appears on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
      q_d  <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
      q_d  <= q;
    end
  end

  assign rise_c = q & ~q_d;
  assign fall_c = ~q & q_d;

endmodule

// File: rtl/adxl345_spi_responder.sv
// adxl345_spi_responder: SPI mode-3 slave emulating the ADXL345 register file.
//   clk, rst_n           : system clock, async active-low reset
//   spi                  : SPI bus (slave modport)
//   sample_valid         : strobe loading x/y/z_sample into the live data registers
//   bw_rate/power_ctl/data_format : writable registers 0x2C/0x2D/0x31
//   wr_strobe, wr_addr   : one-cycle pulse and address of a committed write
//   busy                 : chip select (synchronised) is asserted
//   data_ready           : INT_SOURCE.DATA_READY, only with ADXL_RESP_INT_SOURCE_EN
// Optional feature macro: ADXL_RESP_INT_SOURCE_EN (INT_SOURCE register at 0x30).
module adxl345_spi_responder
  import adxl_resp_pkg::*;
#(
  parameter int unsigned CLK_PER_SCLK_MIN = 8,
  parameter logic [7:0]  DEVID_VALUE      = 8'hE5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  adxl345_spi_responder_if.slave spi,
  input  logic                 sample_valid,
  input  logic [AXIS_W-1:0]    x_sample,
  input  logic [AXIS_W-1:0]    y_sample,
  input  logic [AXIS_W-1:0]    z_sample,
  output logic [7:0]           bw_rate,
  output logic [7:0]           power_ctl,
  output logic [7:0]           data_format,
  output logic                 wr_strobe,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic                 busy
`ifdef ADXL_RESP_INT_SOURCE_EN
  ,
  output logic                 data_ready
`endif
);

  logic sclk_q, sclk_rise_c, sclk_fall_c;
  logic cs_q, cs_rise_c, cs_fall_c;
  logic mosi_meta, mosi_q;

  state_e              state;
  logic [2:0]          bit_cnt;
  logic [7:0]          shreg;
  logic [7:0]          tx;
  logic [ADDR_W-1:0]   addr;
  logic                mb;
  sample_t             live;
  sample_t             shadow;
  logic                miso;
  logic [PHASE_W-1:0]  phase_cnt;

  logic [7:0]          rx_byte_c;
  logic [ADDR_W-1:0]   next_addr_c;
  sample_t             new_sample_c;
  sample_t             snap_c;
  logic                snap_take_c;

  spi_sync_edge #(.RST_VAL(1'b1)) u_sclk_sync (
    .clk(clk), .rst_n(rst_n), .d(spi.spi_sclk),
    .q(sclk_q), .rise_c(sclk_rise_c), .fall_c(sclk_fall_c)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst_n(rst_n), .d(spi.spi_cs),
    .q(cs_q), .rise_c(cs_rise_c), .fall_c(cs_fall_c)
  );

  // MOSI needs only the level; it is sampled on detected sclk rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi_meta <= 1'b0;
      mosi_q    <= 1'b0;
    end else begin
      mosi_meta <= spi.spi_mosi;
      mosi_q    <= mosi_meta;
    end
  end

  assign rx_byte_c    = {shreg[6:0], mosi_q};
  assign next_addr_c  = mb ? ADDR_W'(addr + 6'd1) : addr;
  assign new_sample_c = {z_sample, y_sample, x_sample};
  // A sample arriving in the snapshot cycle goes straight into the shadow.
  assign snap_c       = sample_valid ? new_sample_c : live;
  assign snap_take_c  = (state == ST_CMD) && !cs_rise_c && sclk_rise_c &&
                        (bit_cnt == 3'd7) && rx_byte_c[7];

  assign spi.spi_miso = miso;
  assign busy         = ~cs_q;

  // Read mux; data bytes come from the snapshot passed in, not the live copy.
  function automatic logic [7:0] rd_byte(input logic [ADDR_W-1:0] a, input sample_t snap);
    logic [47:0] flat;
    logic [2:0]  idx;
    flat    = snap;
    idx     = 3'(a - ADDR_DATAX0);
    rd_byte = 8'h00;
    if (is_data_addr(a)) begin
      rd_byte = flat[{idx, 3'b000} +: 8];
    end else begin
      case (a)
        ADDR_DEVID:       rd_byte = DEVID_VALUE;
        ADDR_BW_RATE:     rd_byte = bw_rate;
        ADDR_POWER_CTL:   rd_byte = power_ctl;
        ADDR_DATA_FORMAT: rd_byte = data_format;
`ifdef ADXL_RESP_INT_SOURCE_EN
        ADDR_INT_SOURCE:  rd_byte = {data_ready, 7'b000_0000};
`endif
        default:          rd_byte = 8'h00;
      endcase
    end
  endfunction

  // Live data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live <= '0;
    end else if (sample_valid) begin
      live <= new_sample_c;
    end
  end

`ifdef ADXL_RESP_INT_SOURCE_EN
  // DATA_READY: set wins over the clear caused by a data-range read snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_ready <= 1'b0;
    end else if (sample_valid) begin
      data_ready <= 1'b1;
    end else if (snap_take_c && is_data_addr(rx_byte_c[5:0])) begin
      data_ready <= 1'b0;
    end
  end
`endif

  // Protocol FSM, register file and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      bit_cnt     <= 3'd0;
      shreg       <= 8'h00;
      tx          <= 8'h00;
      addr        <= '0;
      mb          <= 1'b0;
      shadow      <= '0;
      miso        <= 1'b0;
      wr_strobe   <= 1'b0;
      wr_addr     <= '0;
      bw_rate     <= BW_RATE_RST;
      power_ctl   <= POWER_CTL_RST;
      data_format <= DATA_FORMAT_RST;
    end else begin
      wr_strobe <= 1'b0;
      if (cs_rise_c) begin
        // Deselect aborts whatever is in flight, including a partial write byte.
        state <= ST_IDLE;
        miso  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            miso <= 1'b0;
            if (cs_fall_c) begin
              state   <= ST_CMD;
              bit_cnt <= 3'd0;
            end
          end
          ST_CMD: begin
            if (sclk_rise_c) begin
              shreg   <= rx_byte_c;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                addr <= rx_byte_c[5:0];
                mb   <= rx_byte_c[6];
                if (rx_byte_c[7]) begin
                  shadow <= snap_c;
                  tx     <= rd_byte(rx_byte_c[5:0], snap_c);
                  state  <= ST_RD;
                end else begin
                  state <= ST_WR;
                end
              end
            end
          end
          ST_RD: begin
            if (sclk_fall_c) begin
              miso <= tx[7];
              tx   <= {tx[6:0], 1'b0};
            end else if (sclk_rise_c) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                addr <= next_addr_c;
                tx   <= rd_byte(next_addr_c, shadow);
              end
            end
          end
          ST_WR: begin
            if (sclk_rise_c) begin
              shreg   <= rx_byte_c;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (is_writable(addr)) begin
                  wr_strobe <= 1'b1;
                  wr_addr   <= addr;
                  case (addr)
                    ADDR_BW_RATE:   bw_rate     <= rx_byte_c;
                    ADDR_POWER_CTL: power_ctl   <= rx_byte_c;
                    default:        data_format <= rx_byte_c;
                  endcase
                end
                addr <= next_addr_c;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Cycles since the last synchronised sclk edge, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_cnt <= '1;
    end else if (sclk_rise_c || sclk_fall_c) begin
      phase_cnt <= PHASE_W'(1);
    end else if (phase_cnt != '1) begin
      phase_cnt <= phase_cnt + PHASE_W'(1);
    end
  end

  // Each sclk phase must cover the synchroniser and edge-detect latency.
  always_ff @(posedge clk) begin
    if (rst_n && !cs_q && (sclk_rise_c || sclk_fall_c)) begin
      assert (phase_cnt >= PHASE_W'(CLK_PER_SCLK_MIN / 2))
        else $error("sclk phase of %0d clk cycles is below CLK_PER_SCLK_MIN/2", phase_cnt);
    end
  end

endmodule

// File: tb/tb_adxl345_spi_responder.sv
// Directed testbench for adxl345_spi_responder: a bench-side SPI mode-3 master
// drives register reads/writes and the results are compared with hand-computed bytes.
module tb_adxl345_spi_responder;

  localparam int unsigned HALF = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sample_valid;
  logic [15:0] x_sample, y_sample, z_sample;
  logic [7:0]  bw_rate, power_ctl, data_format;
  logic        wr_strobe;
  logic [5:0]  wr_addr;
  logic        busy;
`ifdef ADXL_RESP_INT_SOURCE_EN
  logic        data_ready;
`endif

  int          checks = 0;
  int          errors = 0;
  int          strobe_cnt = 0;
  logic [5:0]  last_wr_addr = 6'h00;
  logic [7:0]  rx;
  logic [7:0]  exp_b [6];

  adxl345_spi_responder_if spi ();

  always #5 clk = ~clk;

  adxl345_spi_responder #(
    .CLK_PER_SCLK_MIN(8),
    .DEVID_VALUE(8'hE5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .spi(spi),
    .sample_valid(sample_valid),
    .x_sample(x_sample),
    .y_sample(y_sample),
    .z_sample(z_sample),
    .bw_rate(bw_rate),
    .power_ctl(power_ctl),
    .data_format(data_format),
    .wr_strobe(wr_strobe),
    .wr_addr(wr_addr),
    .busy(busy)
`ifdef ADXL_RESP_INT_SOURCE_EN
    ,
    .data_ready(data_ready)
`endif
  );

  // Count write strobes and remember the last strobed address.
  always @(posedge clk) begin
    if (rst_n && wr_strobe) begin
      strobe_cnt   = strobe_cnt + 1;
      last_wr_addr = wr_addr;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Mode 3: master changes MOSI on falling sclk, samples MISO on rising sclk.
  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] r);
    r = 8'h00;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      spi.spi_sclk = 1'b0;
      spi.spi_mosi = tx[3'(7 - i)];
      repeat (HALF) @(negedge clk);
      spi.spi_sclk = 1'b1;
      r[3'(7 - i)] = spi.spi_miso;
      repeat (HALF - 1) @(negedge clk);
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] r);
    spi_bits(tx, 8, r);
  endtask

  task automatic cs_sel();
    @(negedge clk);
    spi.spi_cs = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic cs_desel();
    repeat (4) @(negedge clk);
    spi.spi_cs = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic pulse_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    @(negedge clk);
    x_sample     = x;
    y_sample     = y;
    z_sample     = z;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  // Full read transaction: command byte then n bytes compared with exp_b.
  task automatic read_check(input string tag, input logic [7:0] cmd, input int n);
    logic [7:0] r;
    cs_sel();
    spi_byte(cmd, r);
    for (int i = 0; i < n; i++) begin
      spi_byte(8'h00, r);
      check($sformatf("%s[%0d]", tag, i), {8'h00, r}, {8'h00, exp_b[i]});
    end
    cs_desel();
  endtask

  initial begin
    rst_n        = 1'b0;
    spi.spi_sclk = 1'b1;
    spi.spi_cs   = 1'b1;
    spi.spi_mosi = 1'b0;
    sample_valid = 1'b0;
    x_sample     = 16'h0000;
    y_sample     = 16'h0000;
    z_sample     = 16'h0000;
    repeat (5) @(negedge clk);

    // Reset values
    check("rst_miso", {15'h0, spi.spi_miso}, 16'h0000);
    check("rst_wr_strobe", {15'h0, wr_strobe}, 16'h0000);
    check("rst_wr_addr", {10'h0, wr_addr}, 16'h0000);
    check("rst_busy", {15'h0, busy}, 16'h0000);
    check("rst_bw_rate", {8'h0, bw_rate}, 16'h000A);
    check("rst_power_ctl", {8'h0, power_ctl}, 16'h0000);
    check("rst_data_format", {8'h0, data_format}, 16'h0000);
`ifdef ADXL_RESP_INT_SOURCE_EN
    check("rst_data_ready", {15'h0, data_ready}, 16'h0000);
`endif
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // DEVID read
    cs_sel();
    check("devid_busy_hi", {15'h0, busy}, 16'h0001);
    spi_byte(8'h80, rx);
    spi_byte(8'h00, rx);
    check("devid_byte", {8'h0, rx}, 16'h00E5);
    check("devid_busy_mid", {15'h0, busy}, 16'h0001);
    cs_desel();
    check("devid_busy_lo", {15'h0, busy}, 16'h0000);
    check("devid_no_strobe", 16'(strobe_cnt), 16'd0);

    // Burst sample read, little-endian per axis
    pulse_sample(16'h1234, 16'hFF01, 16'h8000);
`ifdef ADXL_RESP_INT_SOURCE_EN
    check("drdy_set", {15'h0, data_ready}, 16'h0001);
`endif
    exp_b = '{8'h34, 8'h12, 8'h01, 8'hFF, 8'h00, 8'h80};
    read_check("burst", 8'hF2, 6);
`ifdef ADXL_RESP_INT_SOURCE_EN
    check("drdy_clr", {15'h0, data_ready}, 16'h0000);
`endif

    // Write POWER_CTL then read it back
    cs_sel();
    spi_byte(8'h2D, rx);
    spi_byte(8'h08, rx);
    cs_desel();
    check("wr_strobe_cnt", 16'(strobe_cnt), 16'd1);
    check("wr_addr", {10'h0, last_wr_addr}, 16'h002D);
    check("power_ctl", {8'h0, power_ctl}, 16'h0008);
    exp_b[0] = 8'h08;
    read_check("pwr_rd", 8'hAD, 1);

    // Aborted write to DATA_FORMAT after 5 data bits
    cs_sel();
    spi_byte(8'h31, rx);
    spi_bits(8'hFF, 5, rx);
    cs_desel();
    check("abort_data_format", {8'h0, data_format}, 16'h0000);
    check("abort_no_strobe", 16'(strobe_cnt), 16'd1);

    // Write to read-only DATAX0 is ignored
    cs_sel();
    spi_byte(8'h32, rx);
    spi_byte(8'h55, rx);
    cs_desel();
    check("ro_no_strobe", 16'(strobe_cnt), 16'd1);
    exp_b[0] = 8'h34;
    read_check("ro_rd", 8'hB2, 1);

    // New sample mid-burst stays invisible until the next transaction
    cs_sel();
    spi_byte(8'hF2, rx);
    spi_byte(8'h00, rx);
    check("coh_b0", {8'h0, rx}, 16'h0034);
    spi_byte(8'h00, rx);
    check("coh_b1", {8'h0, rx}, 16'h0012);
    pulse_sample(16'hAAAA, 16'hFF01, 16'h8000);
    spi_byte(8'h00, rx);
    check("coh_b2", {8'h0, rx}, 16'h0001);
    spi_byte(8'h00, rx);
    check("coh_b3", {8'h0, rx}, 16'h00FF);
    spi_byte(8'h00, rx);
    check("coh_b4", {8'h0, rx}, 16'h0000);
    spi_byte(8'h00, rx);
    check("coh_b5", {8'h0, rx}, 16'h0080);
    cs_desel();
    exp_b[0] = 8'hAA;
    exp_b[1] = 8'hAA;
    read_check("coh_next", 8'hF2, 2);

    // Multi-byte read wraps 0x3F -> 0x00
    exp_b[0] = 8'h00;
    exp_b[1] = 8'hE5;
    read_check("wrap", 8'hFF, 2);

    check("end_strobe_cnt", 16'(strobe_cnt), 16'd1);
    check("end_bw_rate", {8'h0, bw_rate}, 16'h000A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
